// File: rtl/ysyx_22040750_rr_arb_reg_mux_pkg.sv
// Shared constants and debug helpers for the registered round-robin arbiter/mux.
// Optional burst lock is enabled with the macro YSYX_22040750_ARB_LOCK_EN.
package ysyx_22040750_rr_arb_reg_mux_pkg;

   localparam int ARB_N = 64;  // payload width per source
   localparam int ARB_M = 4;   // number of sources

   // Index of the set bit in a one-hot grant vector (0 when the vector is empty).
   function automatic int unsigned onehot_to_idx(input logic [ARB_M-1:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < ARB_M; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/ysyx_22040750_rr_arb_reg_mux_if.sv
// Handshake/bus bundle between M producers, the arbiter and the shared sink.
// I_src_last exists only when YSYX_22040750_ARB_LOCK_EN is defined.
interface ysyx_22040750_rr_arb_reg_mux_if
   import ysyx_22040750_rr_arb_reg_mux_pkg::*;
#(
   parameter int N = ARB_N,
   parameter int M = ARB_M
) ();

   logic [M-1:0]   I_src_valid;
   logic [N*M-1:0] I_src_data;
   logic [M-1:0]   O_src_ready;
   logic           O_valid;
   logic [N-1:0]   O_data;
   logic [M-1:0]   O_grant;
   logic           I_ready;
`ifdef YSYX_22040750_ARB_LOCK_EN
   logic [M-1:0]   I_src_last;

   // Arbiter side.
   modport slave (
      input  I_src_valid, I_src_data, I_src_last, I_ready,
      output O_src_ready, O_valid, O_data, O_grant
   );

   // Producer/sink side.
   modport master (
      output I_src_valid, I_src_data, I_src_last, I_ready,
      input  O_src_ready, O_valid, O_data, O_grant
   );
`else
   // Arbiter side.
   modport slave (
      input  I_src_valid, I_src_data, I_ready,
      output O_src_ready, O_valid, O_data, O_grant
   );

   // Producer/sink side.
   modport master (
      output I_src_valid, I_src_data, I_ready,
      input  O_src_ready, O_valid, O_data, O_grant
   );
`endif

endinterface

// File: rtl/ysyx_22040750_rr_arb_reg_mux_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first request found
// scanning upward circularly from the position after the last-grant pointer.
// Uses a double-width request vector so the wrap-around needs no second pass.
// The lock mask (all ones when unused) restricts which requests may win; it is
// driven from the burst lock when YSYX_22040750_ARB_LOCK_EN is defined.
module ysyx_22040750_rr_pick
   import ysyx_22040750_rr_arb_reg_mux_pkg::*;
#(
   parameter int M = ARB_M
) (
   input  logic [M-1:0] req,
   input  logic [M-1:0] ptr,
   input  logic [M-1:0] lock_mask,
   output logic [M-1:0] g
);

   generate
      if (M == 1) begin : g_single
         // A single source needs no arbitration.
         assign g = req & lock_mask;
      end else begin : g_multi
         logic [M-1:0]   req_m;
         logic [M-1:0]   start;
         logic [2*M-1:0] dbl;
         logic [2*M-1:0] diff;
         logic [2*M-1:0] hit;

         assign req_m = req & lock_mask;
         // Search starts one position above the last grant.
         assign start = {ptr[M-2:0], ptr[M-1]};
         assign dbl   = {req_m, req_m};
         // x & ~(x - b) isolates the lowest set bit of x at or above b; the
         // upper copy catches requests that sit below the start position.
         assign diff  = dbl - {{M{1'b0}}, start};
         assign hit   = dbl & ~diff;
         assign g     = hit[M-1:0] | hit[2*M-1:M];
      end
   endgenerate

endmodule

// File: rtl/ysyx_22040750_rr_arb_reg_mux.sv
// Registered M-way round-robin arbiter with one-hot AND-OR payload select and
// a single output register stage; sustains one beat per cycle under
// backpressure. Reset is asynchronous active-high; the reset source is
// expected to be deasserted synchronously to I_sys_clk.
// Optional: YSYX_22040750_ARB_LOCK_EN keeps a granted source locked until it
// delivers a beat with I_src_last set.
module ysyx_22040750_rr_arb_reg_mux
   import ysyx_22040750_rr_arb_reg_mux_pkg::*;
#(
   parameter int N = ARB_N,
   parameter int M = ARB_M
) (
   input  logic                           I_sys_clk,
   input  logic                           I_rst,
   ysyx_22040750_rr_arb_reg_mux_if.slave  bus
);

   // Last-grant pointer resets to the top source so source 0 wins first.
   localparam logic [M-1:0] PTR_RST = M'(1) << (M - 1);

   logic          load_en;
   logic          any_grant;
   logic [M-1:0]  grant;
   logic [M-1:0]  lock_mask;
   logic [M-1:0]  ptr_q;
   logic          valid_q;
   logic [N-1:0]  data_q;
   logic [M-1:0]  grant_q;
   logic [N-1:0]  sel_data;

   // The register accepts a new beat when empty or draining this cycle.
   assign load_en   = !valid_q | bus.I_ready;
   assign any_grant = |grant;

`ifdef YSYX_22040750_ARB_LOCK_EN
   logic          lock_q;
   logic [M-1:0]  lock_src_q;
   logic          grant_last;

   assign lock_mask  = lock_q ? lock_src_q : '1;
   assign grant_last = |(grant & bus.I_src_last);

   // Lock onto a source after a non-final beat; release on its final beat.
   always_ff @(posedge I_sys_clk or posedge I_rst) begin
      if (I_rst) begin
         lock_q     <= 1'b0;
         lock_src_q <= '0;
      end else if (load_en && any_grant) begin
         lock_q     <= !grant_last;
         lock_src_q <= grant;
      end
   end
`else
   assign lock_mask = '1;
`endif

   ysyx_22040750_rr_pick #(.M(M)) u_pick (
      .req       (bus.I_src_valid),
      .ptr       (ptr_q),
      .lock_mask (lock_mask),
      .g         (grant)
   );

   // Accept only the granted source, and only while the register can load.
   assign bus.O_src_ready = I_rst ? '0 : ({M{load_en}} & grant);

   // One-hot AND-OR select of the granted payload.
   always_comb begin
      // NOTE: default assigned first so every path drives sel_data and no latch is inferred.
      sel_data = '0;
      for (int i = 0; i < M; i++) begin
         sel_data = sel_data | (bus.I_src_data[i*N +: N] & {N{grant[i]}});
      end
   end

   // Output register stage and round-robin pointer.
   always_ff @(posedge I_sys_clk or posedge I_rst) begin
      if (I_rst) begin
         // NOTE: payload register is reset as well, since O_data is observable as 0 after reset.
         valid_q <= 1'b0;
         data_q  <= '0;
         grant_q <= '0;
         ptr_q   <= PTR_RST;
      end else if (load_en) begin
         // NOTE: non-blocking assignments so all state samples pre-edge values.
         if (any_grant) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            grant_q <= grant;
`ifdef YSYX_22040750_ARB_LOCK_EN
            if (grant_last) ptr_q <= grant;
`else
            ptr_q   <= grant;
`endif
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.O_valid = valid_q;
   assign bus.O_data  = data_q;
   assign bus.O_grant = grant_q;

endmodule

// File: tb/tb_ysyx_22040750_rr_arb_reg_mux.sv
// Scoreboard bench for the registered round-robin arbiter/mux.
// A reference model predicts grants from index arithmetic and pushes expected
// beats; a separate monitor pops and compares each beat the sink accepts.
// Build with YSYX_22040750_ARB_LOCK_EN to exercise the burst lock.
module tb_ysyx_22040750_rr_arb_reg_mux;
   import ysyx_22040750_rr_arb_reg_mux_pkg::*;

   localparam int N = ARB_N;
   localparam int M = ARB_M;

   typedef struct {
      logic [N-1:0] data;
      logic [M-1:0] grant;
   } sb_t;

   typedef struct {
      logic [N-1:0] data;
      logic         last;
   } beat_t;

   logic clk;
   logic rst;

   ysyx_22040750_rr_arb_reg_mux_if #(.N(N), .M(M)) bus ();

   ysyx_22040750_rr_arb_reg_mux #(.N(N), .M(M)) dut (
      .I_sys_clk (clk),
      .I_rst     (rst),
      .bus       (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   sb_t   sb_q[$];
   beat_t pend[M][$];

   // Reference model state.
   bit           m_valid;
   int unsigned  m_ptr;
   bit           m_lock;
   int unsigned  m_lock_src;
   logic [M-1:0] m_hs;
   int           rst_epoch;
   int           seen_epoch;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Present the head beat of every source queue.
   task automatic drive_sources();
      for (int i = 0; i < M; i++) begin
         bus.I_src_valid[i] = (pend[i].size() != 0);
         bus.I_src_data[i*N +: N] = (pend[i].size() != 0) ? pend[i][0].data : '0;
`ifdef YSYX_22040750_ARB_LOCK_EN
         bus.I_src_last[i] = (pend[i].size() != 0) ? pend[i][0].last : 1'b1;
`endif
      end
   endtask

   // Advance one cycle: retire beats accepted at this edge, present the next.
   task automatic step(input bit rdy);
      @(posedge clk);
      #2;
      for (int i = 0; i < M; i++) begin
         if (m_hs[i] && pend[i].size() != 0) void'(pend[i].pop_front());
      end
      drive_sources();
      bus.I_ready = rdy;
   endtask

   task automatic push_beat(input int src, input logic [N-1:0] d, input bit last);
      beat_t b;
      b.data = d;
      b.last = last;
      pend[src].push_back(b);
   endtask

   // Reference model: evaluated late in each cycle once inputs are settled.
   always begin
      bit           load_en;
      bit           found;
      int unsigned  gi;
      logic [M-1:0] exp_rdy;
      sb_t          item;
      @(negedge clk);
      #2;
      if (rst || seen_epoch != rst_epoch) begin
         seen_epoch = rst_epoch;
         m_valid    = 0;
         m_ptr      = M - 1;
         m_lock     = 0;
         m_lock_src = 0;
         m_hs       = '0;
         sb_q.delete();
      end
      if (!rst) begin
         load_en = !m_valid || bus.I_ready;
         found   = 0;
         gi      = 0;
         if (m_lock) begin
            if (bus.I_src_valid[m_lock_src]) begin
               found = 1;
               gi    = m_lock_src;
            end
         end else begin
            for (int k = 1; k <= M; k++) begin
               int unsigned c;
               c = (m_ptr + k) % M;
               if (!found && bus.I_src_valid[c]) begin
                  found = 1;
                  gi    = c;
               end
            end
         end
         exp_rdy = (load_en && found) ? (M'(1) << gi) : '0;
         check("o_valid", 64'(bus.O_valid), 64'(m_valid));
         check("src_ready", 64'(bus.O_src_ready), 64'(exp_rdy));
         m_hs = exp_rdy;
         if (load_en) begin
            if (found) begin
               item.data  = bus.I_src_data[gi*N +: N];
               item.grant = M'(1) << gi;
               sb_q.push_back(item);
               m_valid = 1;
`ifdef YSYX_22040750_ARB_LOCK_EN
               if (bus.I_src_last[gi]) begin
                  m_lock = 0;
                  m_ptr  = gi;
               end else begin
                  m_lock     = 1;
                  m_lock_src = gi;
               end
`else
               m_ptr = gi;
`endif
            end else begin
               m_valid = 0;
            end
         end
      end
   end

   // Monitor: every beat the sink accepts must match the next expected beat.
   always @(negedge clk) begin
      sb_t exp_item;
      if (!rst && bus.O_valid && bus.I_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got beat %h with nothing expected at %0t", bus.O_data, $time);
         end else begin
            exp_item = sb_q.pop_front();
            check("sb_data", bus.O_data, exp_item.data);
            check("sb_grant", 64'(bus.O_grant), 64'(exp_item.grant));
            check("sb_grant_idx", 64'(onehot_to_idx(bus.O_grant)), 64'(onehot_to_idx(exp_item.grant)));
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [M-1:0] exp_g[4];
      logic [N-1:0] exp_d[4];

      rst_epoch  = 0;
      seen_epoch = 0;
      m_hs       = '0;
      rst        = 1'b0;
      bus.I_src_valid = '0;
      bus.I_src_data  = '0;
      bus.I_ready     = 1'b1;
`ifdef YSYX_22040750_ARB_LOCK_EN
      bus.I_src_last  = '1;
`endif
      #1 rst = 1'b1;

      // Reset: requests present must not be accepted.
      bus.I_src_valid = '1;
      #2;
      check("rst_src_ready", 64'(bus.O_src_ready), 64'd0);
      check("rst_o_valid", 64'(bus.O_valid), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #4;
      bus.I_src_valid = '0;
      rst = 1'b0;

      // Idle after reset.
      for (int k = 0; k < 5; k++) begin
         step(1'b1);
         #1;
         check("idle_valid", 64'(bus.O_valid), 64'd0);
         check("idle_data", bus.O_data, 64'd0);
         check("idle_grant", 64'(bus.O_grant), 64'd0);
         check("idle_ready", 64'(bus.O_src_ready), 64'd0);
      end

      // All four sources valid: strict rotation from source 0.
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < M; i++) push_beat(i, 64'h1000 + 64'(i), 1'b1);
      step(1'b1);
      for (int k = 0; k < 8; k++) begin
         step(1'b1);
         #1;
         check("rot_grant", 64'(bus.O_grant), 64'(M'(1) << (k % M)));
         check("rot_data", bus.O_data, 64'h1000 + 64'(k % M));
      end
      repeat (3) step(1'b1);

      // Backpressure on a single source: ready pattern 1,0,0,1.
      push_beat(2, 64'h1002, 1'b1);
      push_beat(2, 64'h1002, 1'b1);
      step(1'b1);
      for (int k = 0; k < 2; k++) begin
         step(1'b0);
         #1;
         check("bp_src_ready", 64'(bus.O_src_ready), 64'd0);
         check("bp_valid", 64'(bus.O_valid), 64'd1);
         check("bp_data", bus.O_data, 64'h1002);
         check("bp_grant", 64'(bus.O_grant), 64'b0100);
      end
      step(1'b1);
      step(1'b1);
      #1;
      check("bp_second_beat", 64'(bus.O_valid), 64'd1);
      repeat (3) step(1'b1);

      // Pointer at source 1, then sources 1 and 3 compete: 3 wins first.
      push_beat(1, 64'h2001, 1'b1);
      step(1'b1);
      step(1'b1);
      push_beat(1, 64'h2011, 1'b1);
      push_beat(3, 64'h2013, 1'b1);
      step(1'b1);
      step(1'b1);
      #1;
      check("wrap_grant0", 64'(bus.O_grant), 64'b1000);
      check("wrap_data0", bus.O_data, 64'h2013);
      step(1'b1);
      #1;
      check("wrap_grant1", 64'(bus.O_grant), 64'b0010);
      check("wrap_data1", bus.O_data, 64'h2011);
      repeat (3) step(1'b1);

      // Async reset pulse while a beat is held.
      push_beat(2, 64'h4002, 1'b1);
      step(1'b1);
      step(1'b0);
      #1;
      check("pre_rst_valid", 64'(bus.O_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(bus.O_valid), 64'd0);
      check("async_rst_grant", 64'(bus.O_grant), 64'd0);
      check("async_rst_data", bus.O_data, 64'd0);
      rst = 1'b0;
      rst_epoch++;
      for (int i = 0; i < M; i++) pend[i].delete();

      // Source 0 bursts 3 beats while source 1 waits.
      push_beat(0, 64'h3000, 1'b0);
      push_beat(0, 64'h3001, 1'b0);
      push_beat(0, 64'h3002, 1'b1);
      push_beat(1, 64'h3100, 1'b1);
`ifdef YSYX_22040750_ARB_LOCK_EN
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      exp_d = '{64'h3000, 64'h3001, 64'h3002, 64'h3100};
`else
      exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
      exp_d = '{64'h3000, 64'h3100, 64'h3001, 64'h3002};
`endif
      step(1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
         #1;
         check("burst_grant", 64'(bus.O_grant), 64'(exp_g[k]));
         check("burst_data", bus.O_data, exp_d[k]);
      end
      repeat (3) step(1'b1);

      // Randomized traffic with random sink backpressure.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < M; i++) begin
            if (pend[i].size() == 0 && $urandom_range(1, 0) == 1)
               push_beat(i, {$urandom, $urandom}, 1'($urandom_range(1, 0)));
         end
         step($urandom_range(3, 0) != 0);
      end

      // Drain everything still pending.
      for (int c = 0; c < 200; c++) begin
         step(1'b1);
      end
      step(1'b1);
      #1;
      check("drain_valid", 64'(bus.O_valid), 64'd0);
      check("drain_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
